// File: rtl/mantissa_normalizer_if.sv
// mantissa_normalizer_if: operand/result valid-ready bundle for the mantissa normaliser
interface mantissa_normalizer_if #(parameter int MW = 23, parameter int EW = 8);
  logic              in_valid;
  logic              in_ready;
  logic              sign_i;
  logic [EW-1:0]     exp_i;
  logic [MW+1:0]     mant_i;
  logic              out_valid;
  logic              out_ready;
  logic [EW+MW:0]    result;
  logic              ovf;
  logic              uf;
  logic              zero;
  modport slave (
    input  in_valid, sign_i, exp_i, mant_i, out_ready,
    output in_ready, out_valid, result, ovf, uf, zero
  );
  modport master (
    output in_valid, sign_i, exp_i, mant_i, out_ready,
    input  in_ready, out_valid, result, ovf, uf, zero
  );
endinterface

// File: rtl/mantissa_normalizer.sv
// mantissa_normalizer: carry correction and one-bit-per-cycle leading-zero normalisation
module mantissa_normalizer #(
  parameter int MW = 23,
  parameter int EW = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  mantissa_normalizer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t          r_state, w_state;
  logic            r_sign, w_sign;
  logic [EW-1:0]   r_exp, w_exp;
  logic [MW+1:0]   r_mant, w_mant;
  logic [EW+MW:0]  r_result, w_result;
  logic            r_ovf, w_ovf, r_uf, w_uf, r_zero, w_zero;
  logic [EW:0]     w_exp_inc;
  assign w_exp_inc = {1'b0, r_exp} + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_uf     <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_sign   <= w_sign;
      r_exp    <= w_exp;
      r_mant   <= w_mant;
      r_result <= w_result;
      r_ovf    <= w_ovf;
      r_uf     <= w_uf;
      r_zero   <= w_zero;
    end
  end
  always_comb begin
    w_state  = r_state;
    w_sign   = r_sign;
    w_exp    = r_exp;
    w_mant   = r_mant;
    w_result = r_result;
    w_ovf    = r_ovf;
    w_uf     = r_uf;
    w_zero   = r_zero;
    case (r_state)
      IDLE: if (bus.in_valid) begin
        w_state = SHIFT;
        w_sign  = bus.sign_i;
        w_exp   = bus.exp_i;
        w_mant  = bus.mant_i;
        w_ovf   = 1'b0;
        w_uf    = 1'b0;
        w_zero  = 1'b0;
      end
      SHIFT: begin
        w_state = DONE;
        // exponent only ever decreases while shifting, so all-ones here means it was captured that way
        if (&r_exp) w_result = {r_sign, r_exp, r_mant[MW-1:0]};
        else if (r_mant == '0) begin
          w_result = {r_sign, {EW{1'b0}}, {MW{1'b0}}};
          w_zero   = 1'b1;
        end else if (r_mant[MW+1]) begin
          if (w_exp_inc >= {1'b0, {EW{1'b1}}}) begin
            w_result = {r_sign, {EW{1'b1}}, {MW{1'b0}}};
            w_ovf    = 1'b1;
          end else begin
            w_exp    = w_exp_inc[EW-1:0];
            w_mant   = r_mant >> 1;
            w_result = {r_sign, w_exp_inc[EW-1:0], r_mant[MW:1]};
          end
        end else if (r_mant[MW]) w_result = {r_sign, r_exp, r_mant[MW-1:0]};
        else if (r_exp <= EW'(1)) begin
          w_result = {r_sign, {EW{1'b0}}, r_mant[MW-1:0]};
          w_uf     = 1'b1;
        end else begin
          w_state = SHIFT;
          w_mant  = r_mant << 1;
          w_exp   = r_exp - 1'b1;
        end
      end
      DONE: w_state = bus.out_ready ? IDLE : DONE;
      default: w_state = IDLE;
    endcase
  end
  assign bus.in_ready  = rst_n && (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.ovf       = r_ovf;
  assign bus.uf        = r_uf;
  assign bus.zero      = r_zero;
endmodule
